// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and latency helper.
// Optional build macro used by the shifter files: SHIFTER_FLAGS_EN.
package shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_t;

    // Number of register stages when one register follows every reg_every mux levels.
    function automatic int latency(input int cnt_w, input int reg_every);
        return (cnt_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts or rotates by AMT when en is set.
// With SHIFTER_FLAGS_EN defined it also tracks the last bit shifted out.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT   = 1
) (
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic             sign,
    input  logic [WIDTH-1:0] src,
`ifdef SHIFTER_FLAGS_EN
    input  logic             carry_prev,
    output logic             carry_next,
`endif
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = src;
`ifdef SHIFTER_FLAGS_EN
        carry_next = carry_prev;
`endif
        if (en) begin
            case (op)
                OP_ROL: res = {src[WIDTH-AMT-1:0], src[WIDTH-1:WIDTH-AMT]};
                OP_SLL: res = {src[WIDTH-AMT-1:0], {AMT{1'b0}}};
                OP_ROR: res = {src[AMT-1:0], src[WIDTH-1:AMT]};
                OP_SRL: res = {{AMT{1'b0}}, src[WIDTH-1:AMT]};
                OP_SRA: res = {{AMT{sign}}, src[WIDTH-1:AMT]};
                default: res = src;
            endcase
`ifdef SHIFTER_FLAGS_EN
            // The last nonzero level decides the carry, which equals the overall last bit out.
            case (op)
                OP_ROL, OP_SLL:         carry_next = src[WIDTH-AMT];
                OP_ROR, OP_SRL, OP_SRA: carry_next = src[AMT-1];
                default:                carry_next = carry_prev;
            endcase
`endif
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake and a register after every REG_EVERY levels.
// Define SHIFTER_FLAGS_EN to add the registered out_zero and out_carry flags.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_cnt,
    input  logic [OP_W-1:0]          in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef SHIFTER_FLAGS_EN
   ,output logic                     out_zero,
    output logic                     out_carry
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int LAT   = latency(CNT_W, REG_EVERY);

    logic [WIDTH-1:0] src_data [CNT_W];
    logic [WIDTH-1:0] res_data [CNT_W];
    logic [CNT_W-1:0] src_cnt  [CNT_W];
    logic [OP_W-1:0]  src_op   [CNT_W];
    logic             src_sign [CNT_W];

    logic [WIDTH-1:0] nxt_data [LAT];
    logic [CNT_W-1:0] nxt_cnt  [LAT];
    logic [OP_W-1:0]  nxt_op   [LAT];
    logic             nxt_sign [LAT];

    logic [WIDTH-1:0] st_data  [LAT];
    logic [CNT_W-1:0] st_cnt   [LAT];
    logic [OP_W-1:0]  st_op    [LAT];
    logic             st_sign  [LAT];

    logic [LAT-1:0]   valid;
    logic [LAT-1:0]   load;

`ifdef SHIFTER_FLAGS_EN
    logic             src_carry [CNT_W];
    logic             res_carry [CNT_W];
    logic             nxt_carry [LAT];
    logic             st_carry  [LAT];
    logic             zero_q;
`endif

    // Level j shifts by 2^(CNT_W-1-j); its operand comes from the port, a stage register or the previous level.
    for (genvar j = 0; j < CNT_W; j++) begin : g_level
        if (j == 0) begin : g_head
            assign src_data[j] = in_data;
            assign src_cnt[j]  = in_cnt;
            assign src_op[j]   = in_op;
            assign src_sign[j] = in_data[WIDTH-1];
`ifdef SHIFTER_FLAGS_EN
            assign src_carry[j] = 1'b0;
`endif
        end else if (j % REG_EVERY == 0) begin : g_reg
            assign src_data[j] = st_data[j/REG_EVERY-1];
            assign src_cnt[j]  = st_cnt[j/REG_EVERY-1];
            assign src_op[j]   = st_op[j/REG_EVERY-1];
            assign src_sign[j] = st_sign[j/REG_EVERY-1];
`ifdef SHIFTER_FLAGS_EN
            assign src_carry[j] = st_carry[j/REG_EVERY-1];
`endif
        end else begin : g_comb
            assign src_data[j] = res_data[j-1];
            assign src_cnt[j]  = src_cnt[j-1];
            assign src_op[j]   = src_op[j-1];
            assign src_sign[j] = src_sign[j-1];
`ifdef SHIFTER_FLAGS_EN
            assign src_carry[j] = res_carry[j-1];
`endif
        end

        shift_level #(
            .WIDTH(WIDTH),
            .AMT  (1 << (CNT_W - 1 - j))
        ) u_level (
            .en        (src_cnt[j][CNT_W-1-j]),
            .op        (src_op[j]),
            .sign      (src_sign[j]),
            .src       (src_data[j]),
`ifdef SHIFTER_FLAGS_EN
            .carry_prev(src_carry[j]),
            .carry_next(res_carry[j]),
`endif
            .res       (res_data[j])
        );
    end

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int JL = ((s + 1) * REG_EVERY < CNT_W) ? (s + 1) * REG_EVERY - 1 : CNT_W - 1;
        assign nxt_data[s] = res_data[JL];
        assign nxt_cnt[s]  = src_cnt[JL];
        assign nxt_op[s]   = src_op[JL];
        assign nxt_sign[s] = src_sign[JL];
`ifdef SHIFTER_FLAGS_EN
        assign nxt_carry[s] = res_carry[JL];
`endif
    end

    // A stage may load when it is empty or its content leaves this cycle; bubbles collapse this way.
    always_comb begin
        load = '0;
        load[LAT-1] = !valid[LAT-1] || out_ready;
        for (int s = LAT - 2; s >= 0; s--) begin
            load[s] = !valid[s] || load[s+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                st_data[s] <= '0;
                st_cnt[s]  <= '0;
                st_op[s]   <= '0;
                st_sign[s] <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
                st_carry[s] <= 1'b0;
`endif
            end
`ifdef SHIFTER_FLAGS_EN
            zero_q <= 1'b0;
`endif
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (load[s]) begin
                    valid[s]   <= (s == 0) ? in_valid : valid[s-1];
                    st_data[s] <= nxt_data[s];
                    st_cnt[s]  <= nxt_cnt[s];
                    st_op[s]   <= nxt_op[s];
                    st_sign[s] <= nxt_sign[s];
`ifdef SHIFTER_FLAGS_EN
                    st_carry[s] <= nxt_carry[s];
`endif
                end
            end
`ifdef SHIFTER_FLAGS_EN
            if (load[LAT-1]) begin
                zero_q <= (nxt_data[LAT-1] == '0);
            end
`endif
        end
    end

    assign in_ready  = rst_n && load[0];
    assign out_valid = valid[LAT-1];
    assign out_data  = st_data[LAT-1];
`ifdef SHIFTER_FLAGS_EN
    assign out_zero  = zero_q;
    assign out_carry = st_carry[LAT-1];
`endif

endmodule
